// File: rtl/adsr_envelope.sv
// ADSR envelope generator with a prescaled step clock per phase and a
// coalescing one-shot handoff of each new envelope value to a multiplier.
module adsr_envelope #(
  parameter int C_WIDTH      = 8,
  parameter int C_RATE_WIDTH = 16
) (
  input  logic                    ctl_clk,
  input  logic                    reset,
  input  logic                    gate,
  input  logic [C_RATE_WIDTH-1:0] attack_rate,
  input  logic [C_RATE_WIDTH-1:0] decay_rate,
  input  logic [C_WIDTH-1:0]      sustain_level,
  input  logic [C_RATE_WIDTH-1:0] release_rate,
  output logic [C_WIDTH-1:0]      env,
  output logic                    env_strobe,
  output logic                    active,
  output logic [C_WIDTH-1:0]      mul_b,
  output logic                    mul_trigger,
  input  logic                    mul_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  localparam logic [C_WIDTH-1:0] ENV_MAX = '1;

  state_t                  state;
  state_t                  state_next;
  logic [C_WIDTH-1:0]      env_next;
  logic [C_RATE_WIDTH-1:0] cnt;
  logic [C_RATE_WIDTH-1:0] cnt_next;
  logic [C_RATE_WIDTH-1:0] rate_sel;
  logic                    gate_q;
  logic                    gate_armed;
  logic                    pending;
  logic                    rise;
  logic                    fall;
  logic                    step;
  logic                    env_changed;
  logic                    issue;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statements can infer a latch.
    state_next = state;
    env_next   = env;
    rate_sel   = '0;

    // gate_armed stays low for the first clock after reset so a gate that
    // is already high is registered rather than seen as a new note.
    rise = gate_armed & gate & ~gate_q;
    fall = ~gate & gate_q;

    case (state)
      S_ATTACK:  rate_sel = attack_rate;
      S_DECAY:   rate_sel = decay_rate;
      S_RELEASE: rate_sel = release_rate;
      default:   rate_sel = '0;
    endcase

    // >= rather than == so a rate lowered below the running count steps at once.
    step = (cnt >= rate_sel);

    if (rise) begin
      state_next = S_ATTACK;
    end else if (fall && (state inside {S_ATTACK, S_DECAY, S_SUSTAIN})) begin
      state_next = S_RELEASE;
    end else begin
      case (state)
        S_IDLE: env_next = '0;
        S_ATTACK: begin
          if (env == ENV_MAX) begin
            state_next = S_DECAY;
          end else if (step) begin
            env_next = env + 1'b1;
            if (env == ENV_MAX - 1'b1) state_next = S_DECAY;
          end
        end
        S_DECAY: begin
          if (env <= sustain_level) begin
            state_next = S_SUSTAIN;
            env_next   = sustain_level;
          end else if (step) begin
            env_next = env - 1'b1;
          end
        end
        S_SUSTAIN: env_next = sustain_level;
        S_RELEASE: begin
          if (env == '0) begin
            state_next = S_IDLE;
          end else if (step) begin
            env_next = env - 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end

    cnt_next    = (rise || step || (state_next != state)) ? '0 : cnt + 1'b1;
    env_changed = (env_next != env);
    // Blocking on mul_trigger spaces issues at least one idle cycle apart.
    issue       = pending & mul_ready & ~mul_trigger;
  end

  always_ff @(posedge ctl_clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state       <= S_IDLE;
      env         <= '0;
      cnt         <= '0;
      gate_q      <= 1'b0;
      gate_armed  <= 1'b0;
      pending     <= 1'b0;
      mul_b       <= '0;
      mul_trigger <= 1'b0;
      env_strobe  <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_next;
      env         <= env_next;
      cnt         <= cnt_next;
      gate_q      <= gate;
      gate_armed  <= 1'b1;
      // A fresh change wins over a same-cycle issue so it is not lost.
      pending     <= env_changed | (pending & ~issue);
      mul_trigger <= issue;
      env_strobe  <= env_changed;
      active      <= (state_next != S_IDLE);
      if (issue) mul_b <= env;
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: a hand-computed vector table for the
// short corner cases, followed by long hand-written envelope sequences.
module tb_adsr_envelope;

  logic        ctl_clk = 1'b0;
  logic        reset;
  logic        gate;
  logic [15:0] attack_rate;
  logic [15:0] decay_rate;
  logic [7:0]  sustain_level;
  logic [15:0] release_rate;
  logic [7:0]  env;
  logic        env_strobe;
  logic        active;
  logic [7:0]  mul_b;
  logic        mul_trigger;
  logic        mul_ready;

  int n_checks = 0;
  int n_errors = 0;

  adsr_envelope #(.C_WIDTH(8), .C_RATE_WIDTH(16)) dut (
    .ctl_clk      (ctl_clk),
    .reset        (reset),
    .gate         (gate),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .sustain_level(sustain_level),
    .release_rate (release_rate),
    .env          (env),
    .env_strobe   (env_strobe),
    .active       (active),
    .mul_b        (mul_b),
    .mul_trigger  (mul_trigger),
    .mul_ready    (mul_ready)
  );

  always #5 ctl_clk = ~ctl_clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge ctl_clk);
    #1;
  endtask

  // Every trigger must carry the env value present at the issuing edge and
  // must not follow another trigger directly.
  logic       prev_trig;
  logic [7:0] prev_env;
  always @(negedge ctl_clk) begin
    if (!reset) begin
      prev_trig = 1'b0;
      prev_env  = 8'h00;
    end else begin
      if (mul_trigger) begin
        check("trig_not_consecutive", {31'd0, prev_trig}, 32'd0);
        check("mul_b_is_env", {24'd0, mul_b}, {24'd0, prev_env});
      end
      prev_trig = mul_trigger;
      prev_env  = env;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic        gate;
    logic [15:0] ar;
    logic [15:0] rr;
    logic        ready;
    logic [7:0]  e_env;
    logic        e_strobe;
    logic        e_active;
    logic        e_trig;
    logic [7:0]  e_mul_b;
  } vec_t;

  vec_t vecs [24];

  initial begin
    int   trig_count;
    bit   found;
    bit   seen_top;
    logic [7:0] last_env;

    vecs = '{
      //  gate  ar     rr     rdy   env    stb   act   trg   mul_b
      '{1'b0, 16'd1, 16'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00},  // arm after reset
      '{1'b1, 16'd1, 16'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00},  // rise -> ATTACK
      '{1'b1, 16'd1, 16'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b1, 16'd1, 16'd0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00},  // first step
      '{1'b1, 16'd1, 16'd0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01},
      '{1'b1, 16'd1, 16'd0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h01},
      '{1'b1, 16'd0, 16'd0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h02},  // rate -> 0
      '{1'b1, 16'd0, 16'd0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'h02},  // coalesced
      '{1'b1, 16'd5, 16'd0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h04},  // rate -> 5
      '{1'b1, 16'd5, 16'd0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 8'h04},
      '{1'b1, 16'd5, 16'd0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 8'h04},
      '{1'b1, 16'd1, 16'd0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 8'h04},  // count 3 > new rate 1
      '{1'b0, 16'd0, 16'd0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h05},  // fall beats step
      '{1'b0, 16'd0, 16'd0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'h05},
      '{1'b0, 16'd0, 16'd0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h04},
      '{1'b0, 16'd0, 16'd0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h04},
      '{1'b1, 16'd0, 16'd0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h02},  // rise in RELEASE
      '{1'b1, 16'd0, 16'd0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 8'h02},
      '{1'b0, 16'd0, 16'd0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h03},
      '{1'b0, 16'd0, 16'd0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h03},
      '{1'b0, 16'd0, 16'd0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h02},
      '{1'b0, 16'd0, 16'd0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h02},
      '{1'b0, 16'd0, 16'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00},  // -> IDLE
      '{1'b0, 16'd0, 16'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}
    };

    reset         = 1'b0;
    gate          = 1'b0;
    attack_rate   = 16'd0;
    decay_rate    = 16'd0;
    sustain_level = 8'h80;
    release_rate  = 16'd0;
    mul_ready     = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_env", {24'd0, env}, 32'h0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_strobe", {31'd0, env_strobe}, 32'd0);
    check("rst_trig", {31'd0, mul_trigger}, 32'd0);
    check("rst_mul_b", {24'd0, mul_b}, 32'h0);
    reset = 1'b1;

    // Vector table
    for (int i = 0; i < 24; i++) begin
      gate         = vecs[i].gate;
      attack_rate  = vecs[i].ar;
      release_rate = vecs[i].rr;
      mul_ready    = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_env", i), {24'd0, env}, {24'd0, vecs[i].e_env});
      check($sformatf("vec%0d_strobe", i), {31'd0, env_strobe}, {31'd0, vecs[i].e_strobe});
      check($sformatf("vec%0d_active", i), {31'd0, active}, {31'd0, vecs[i].e_active});
      check($sformatf("vec%0d_trig", i), {31'd0, mul_trigger}, {31'd0, vecs[i].e_trig});
      check($sformatf("vec%0d_mul_b", i), {24'd0, mul_b}, {24'd0, vecs[i].e_mul_b});
    end

    // Attack at rate 3: one step and one strobe every 4th clock
    attack_rate = 16'd3;
    gate        = 1'b1;
    tick();
    check("r3_start_env", {24'd0, env}, 32'h0);
    trig_count = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("r3_env_k%0d", k), {24'd0, env}, k / 4);
      check($sformatf("r3_strobe_k%0d", k), {31'd0, env_strobe}, {31'd0, (k % 4) == 0});
      if (mul_trigger) trig_count++;
    end
    check("r3_trig_count", trig_count, 32'd4);

    // Return to IDLE before the full-envelope run
    gate         = 1'b0;
    release_rate = 16'd0;
    found        = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      if (!active) found = 1'b1;
    end
    check("r3_back_to_idle", {31'd0, found}, 32'd1);

    // Full attack / decay / sustain at rate 0
    attack_rate   = 16'd0;
    decay_rate    = 16'd0;
    sustain_level = 8'h80;
    gate          = 1'b1;
    tick();
    check("full_rise_env", {24'd0, env}, 32'h0);
    check("full_rise_active", {31'd0, active}, 32'd1);
    for (int k = 1; k <= 255; k++) begin
      tick();
      check($sformatf("attack_env_%0d", k), {24'd0, env}, k);
    end
    for (int k = 1; k <= 127; k++) begin
      tick();
      check($sformatf("decay_env_%0d", k), {24'd0, env}, 255 - k);
    end
    tick();
    check("sustain_env", {24'd0, env}, 32'h80);
    check("sustain_strobe", {31'd0, env_strobe}, 32'd0);
    tick();
    tick();
    tick();
    check("sustain_env_hold", {24'd0, env}, 32'h80);
    check("sustain_mul_b", {24'd0, mul_b}, 32'h80);
    check("sustain_trig_idle", {31'd0, mul_trigger}, 32'd0);

    // Sustain follows the level input with one clock of latency
    sustain_level = 8'h70;
    tick();
    check("sustain_follow_env", {24'd0, env}, 32'h70);
    check("sustain_follow_strobe", {31'd0, env_strobe}, 32'd1);
    sustain_level = 8'h80;
    tick();
    check("sustain_restore_env", {24'd0, env}, 32'h80);
    tick();
    tick();

    // Release at rate 1: one decrement every 2nd clock down to 0, then IDLE
    release_rate = 16'd1;
    gate         = 1'b0;
    tick();
    check("release_entry_env", {24'd0, env}, 32'h80);
    check("release_entry_active", {31'd0, active}, 32'd1);
    for (int k = 1; k <= 256; k++) begin
      tick();
      check($sformatf("release_env_k%0d", k), {24'd0, env}, 128 - k / 2);
    end
    tick();
    check("release_idle_active", {31'd0, active}, 32'd0);
    check("release_idle_env", {24'd0, env}, 32'h0);

    // Re-attack from RELEASE at 0x40
    sustain_level = 8'h40;
    gate          = 1'b1;
    found         = 1'b0;
    seen_top      = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      tick();
      if (env == 8'hFF) seen_top = 1'b1;
      if (seen_top && env == 8'h40) found = 1'b1;
    end
    check("reach_sustain_40", {31'd0, found}, 32'd1);
    tick();
    tick();
    release_rate = 16'd3;
    gate         = 1'b0;
    tick();
    check("rel40_env", {24'd0, env}, 32'h40);
    check("rel40_active", {31'd0, active}, 32'd1);
    gate = 1'b1;
    tick();
    check("reattack_env_hold", {24'd0, env}, 32'h40);
    tick();
    check("reattack_env_inc", {24'd0, env}, 32'h41);

    // Multiplier back-pressure: nothing while not ready, then one issue
    mul_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("stall_trig_%0d", k), {31'd0, mul_trigger}, 32'd0);
    end
    last_env  = env;
    mul_ready = 1'b1;
    tick();
    check("unstall_trig", {31'd0, mul_trigger}, 32'd1);
    check("unstall_mul_b", {24'd0, mul_b}, {24'd0, last_env});
    tick();
    check("unstall_trig_single", {31'd0, mul_trigger}, 32'd0);

    // Asynchronous reset in DECAY at 0x90
    found    = 1'b0;
    seen_top = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      tick();
      if (env == 8'hFF) seen_top = 1'b1;
      if (seen_top && env == 8'h90) found = 1'b1;
    end
    check("reach_decay_90", {31'd0, found}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_env", {24'd0, env}, 32'h0);
    check("async_rst_active", {31'd0, active}, 32'd0);
    check("async_rst_strobe", {31'd0, env_strobe}, 32'd0);
    check("async_rst_trig", {31'd0, mul_trigger}, 32'd0);
    check("async_rst_mul_b", {24'd0, mul_b}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_active_1", {31'd0, active}, 32'd0);
    check("post_rst_env_1", {24'd0, env}, 32'h0);
    tick();
    tick();
    tick();
    check("post_rst_active_4", {31'd0, active}, 32'd0);
    check("post_rst_env_4", {24'd0, env}, 32'h0);
    check("post_rst_trig_4", {31'd0, mul_trigger}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
